// File: rtl/serial_collector_if.sv
// Bus between a bit-serial producer and serial_collector: frame control,
// serial data and the valid/ack word handshake.
interface serial_collector_if #(
  parameter int N = 8
);
  logic         enable;
  logic         start;
  logic         serial_in;
  logic         ack;
  logic [N-1:0] data_out;
  logic         valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  // Producer / consumer side: drives the stream and acknowledges words.
  modport master (
    output enable, start, serial_in, ack,
    input  data_out, valid, busy, overrun, parity_err
  );

  // Collector side.
  modport slave (
    input  enable, start, serial_in, ack,
    output data_out, valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/serial_collector.sv
// Serial-in, parallel-out word collector for an LSB-first stream.
// After a start pulse it samples N bits (one per enabled edge), then
// presents the word on data_out with a valid/ack handshake and a sticky
// overrun flag.
// Optional feature: define SERIAL_COLLECTOR_PARITY_EN to append one even
// parity bit per frame (extra PAR state) and drive parity_err.
module serial_collector #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_collector_if.slave  bus
);

  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIAL_COLLECTOR_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          complete;
  logic [N-1:0]  word;
`ifdef SERIAL_COLLECTOR_PARITY_EN
  logic          perr_q, perr_d;
`endif

  // Next-state, shifting, word capture and handshake bookkeeping.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;
    word      = {bus.serial_in, shift_q[N-1:1]};
`ifdef SERIAL_COLLECTOR_PARITY_EN
    perr_d    = perr_q;
`endif

    // Acknowledge is honoured even while enable is low.
    if (bus.ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (bus.enable) begin
      if (bus.start) begin
        // Start (or restart): discard any partial word, sample nothing.
        state_d = SHIFT;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        case (state_q)
          SHIFT: begin
            shift_d = word;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
              state_d = PAR;
`else
              state_d  = IDLE;
              data_d   = word;
              complete = 1'b1;
`endif
            end
          end
`ifdef SERIAL_COLLECTOR_PARITY_EN
          PAR: begin
            state_d  = IDLE;
            data_d   = shift_q;
            perr_d   = (^shift_q) ^ bus.serial_in;
            complete = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end

    // A new word always becomes valid; overwriting an unacknowledged one
    // flags overrun unless it is acknowledged on this same edge.
    if (complete) begin
      valid_d = 1'b1;
      if (valid_q && !bus.ack) overrun_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SERIAL_COLLECTOR_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // values computed before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SERIAL_COLLECTOR_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overrun  = overrun_q;
`ifdef SERIAL_COLLECTOR_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_collector.sv
// Directed bench for serial_collector: frames are driven bit by bit, the
// expected word/overrun/parity result is queued when a frame is launched
// and popped when the frame completes.
module tb_serial_collector;

  localparam int N = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  serial_collector_if #(.N(N)) sif ();

  serial_collector #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] data;
    logic         ovr;
    logic         perr;
  } exp_t;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  bit           model_valid = 1'b0;
  logic [N-1:0] model_data  = '0;

`ifdef SERIAL_COLLECTOR_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},    sif.data_out,   0);
    check({tag, "_valid"},   sif.valid,      0);
    check({tag, "_busy"},    sif.busy,       0);
    check({tag, "_overrun"}, sif.overrun,    0);
    check({tag, "_perr"},    sif.parity_err, 0);
  endtask

  // One full frame: start edge, N data bits (optionally with an enable-low
  // gap of gap_len cycles before bit gap_pos), then the parity bit when the
  // parity build is active. ack_last raises ack on the completion edge.
  task automatic run_frame(input logic [N-1:0] w, input int gap_pos, input int gap_len,
                           input bit ack_last, input bit par_bit);
    exp_t e;
    e.data = w;
    e.ovr  = model_valid && !ack_last;
    e.perr = PAR_BUILD ? ((^w) ^ par_bit) : 1'b0;
    sb.push_back(e);

    sif.enable = 1'b1;
    sif.start  = 1'b1;
    tick();
    sif.start = 1'b0;
    check("busy_after_start", sif.busy, 1);

    for (int i = 0; i < N; i++) begin
      if (i == gap_pos) begin
        sif.enable = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          // Garbage data and a stray start must both be ignored while frozen.
          sif.serial_in = ~w[i];
          sif.start     = 1'b1;
          tick();
          check("gap_busy", sif.busy, 1);
          check("gap_data_held", sif.data_out, model_data);
        end
        sif.start  = 1'b0;
        sif.enable = 1'b1;
      end
      sif.serial_in = w[i];
      if (!PAR_BUILD && i == N - 1) sif.ack = ack_last;
      tick();
      sif.ack = 1'b0;
      check("busy_bit", sif.busy, (i == N - 1 && !PAR_BUILD) ? 0 : 1);
      if (i == N / 2) check("valid_mid_frame", sif.valid, model_valid);
    end

    if (PAR_BUILD) begin
      sif.serial_in = par_bit;
      sif.ack       = ack_last;
      tick();
      sif.ack = 1'b0;
      check("busy_after_par", sif.busy, 0);
    end

    e = sb.pop_front();
    check("data_out", sif.data_out,   e.data);
    check("valid",    sif.valid,      1);
    check("overrun",  sif.overrun,    e.ovr);
    check("parity",   sif.parity_err, e.perr);
    model_valid = 1'b1;
    model_data  = w;
  endtask

  task automatic do_ack(input bit en);
    sif.enable = en;
    sif.ack    = 1'b1;
    tick();
    sif.ack    = 1'b0;
    sif.enable = 1'b1;
    model_valid = 1'b0;
    check("ack_valid",   sif.valid,    0);
    check("ack_overrun", sif.overrun,  0);
    check("ack_data",    sif.data_out, model_data);
  endtask

  // Start a frame and feed a few bits without finishing it.
  task automatic partial_frame(input logic [N-1:0] w, input int nbits);
    sif.enable = 1'b1;
    sif.start  = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sif.serial_in = w[i];
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.enable    = 1'b0;
    sif.start     = 1'b0;
    sif.serial_in = 1'b0;
    sif.ack       = 1'b0;
    reset_n       = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic frame, then acknowledge; a second ack with valid low is ignored.
    run_frame(8'hA5, -1, 0, 1'b0, 1'b0);
    do_ack(1'b1);
    do_ack(1'b1);

    // Same frame with a 3-cycle enable-low gap mid-frame; ack while enable low.
    run_frame(8'hA5, 4, 3, 1'b0, 1'b0);
    do_ack(1'b0);

    // Overrun: second word overwrites an unacknowledged one.
    run_frame(8'h3C, -1, 0, 1'b0, 1'b0);
    run_frame(8'hC3, -1, 0, 1'b0, 1'b0);
    do_ack(1'b1);

    // Completion on the same edge as ack of the previous word.
    run_frame(8'h3C, -1, 0, 1'b0, 1'b1);
    run_frame(8'h5A, -1, 0, 1'b1, 1'b0);
    do_ack(1'b1);

    // Restart after 4 zero bits; the new word must be all ones.
    partial_frame(8'h00, 4);
    check("restart_busy", sif.busy, 1);
    run_frame(8'hFF, -1, 0, 1'b0, 1'b0);
    do_ack(1'b1);

    // Overrun stays sticky across several overwrites.
    run_frame(8'h11, -1, 0, 1'b0, 1'b0);
    run_frame(8'h22, -1, 0, 1'b0, 1'b0);
    run_frame(8'h33, 2, 1, 1'b0, 1'b1);
    do_ack(1'b1);

    // Parity frames (parity_err expected 0 in the default build).
    run_frame(8'h07, -1, 0, 1'b0, 1'b1);
    do_ack(1'b1);
    run_frame(8'h07, -1, 0, 1'b0, 1'b0);

    // Reset mid-frame while a word is still valid: outputs clear at once.
    partial_frame(8'hF0, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_frame");
    model_valid = 1'b0;
    model_data  = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_frame(8'h96, -1, 0, 1'b0, 1'b1);

    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_collector.md
# serial_collector

Serial-in, parallel-out word collector: the receive end of the LSB-first serial stream produced by the multiplier datapath's right-shift registers. After a start pulse it samples one bit per enabled clock for N clocks, assembles the word, and presents it as a registered parallel word. The word is held with a valid/ack handshake and an overrun flag. It sits after a shifting stage wherever a serialized operand or product must be reassembled, such as a bit-serial link between multiplier stages or a test readback path.

## Interface
- N, 8, word width in bits; N >= 2.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  clock enable; low freezes FSM, bit counter and shift register.
- start  input  1  frame start; sampled only when enable=1.
- serial_in  input  1  serial data, LSB first.
- ack  input  1  consumer accepts data_out; honoured regardless of enable.
- data_out  output  N  last completed word.
- valid  output  1  data_out holds an unacknowledged word.
- busy  output  1  frame in progress.
- overrun  output  1  an unacknowledged word was overwritten.
- parity_err  output  1  parity check result of the last word; always 0 without the parity macro.

## Operation
- Reset (asynchronous) sets state IDLE, counter 0, shift register 0, data_out 0, valid 0, busy 0, overrun 0, parity_err 0.
- States:
  - IDLE
  - SHIFT
  - PAR (present only with the parity macro).
- All transitions and shifts occur only on edges with enable=1.
- IDLE:
  - start=1 moves to SHIFT, clears the counter and the shift register, and sets busy=1.
  - No bit is sampled on the start edge.
- SHIFT:
  - Each enabled edge applies shift_reg <= {serial_in, shift_reg[N-1:1]} and increments the counter.
  - On the Nth sample (counter == N-1), without parity: data_out <= the assembled word, valid <= 1, and the FSM returns to IDLE with busy=0.
  - With parity, the FSM goes to PAR instead.
- PAR:
  - Samples one parity bit and sets parity_err <= (^word) ^ serial_in (even parity).
  - Loads data_out, sets valid, and returns to IDLE.
- start=1 while busy: the frame restarts. The partial word is discarded, the counter resets to 0, and no bit is sampled on that edge.
- Handshake:
  - ack=1 with valid=1 clears valid and overrun on that edge.
  - ack with valid=0 is ignored.
- Completion edge:
  - Completion with valid=1 and no ack: data_out is overwritten, valid stays 1, and overrun is set (sticky until ack).
  - Completion on the same edge as ack: the new word loads, valid stays 1, and overrun is cleared, not set.
- Counter width is $clog2(N). No arithmetic is performed on data.

## Timing
- Start edge k (the edge on which the upstream shifter parallel-loads): bit i is sampled at enabled edge k+1+i.
- valid rises after edge k+N, or k+N+1 with parity. This assumes enable held high; each low-enable cycle adds one cycle.
- busy is high from after edge k until the completion edge.
- Back-to-back frames: start may be asserted on the completion edge's following cycle. Start asserted on the completion edge itself restarts the frame and the word is lost; this is as specified.
- data_out changes only on completion edges. parity_err changes only on completion edges.
- Reset assertion mid-frame clears everything immediately. No partial word is emitted.

## Configuration
- SERIAL_COLLECTOR_PARITY_EN defined:
  - Adds the PAR state. Frames are N+1 bits.
  - parity_err is driven as described under Operation.
- SERIAL_COLLECTOR_PARITY_EN undefined:
  - No PAR state. Frames are N bits.
  - parity_err is tied to 0.

## Test plan
- N=8, enable=1. Start at edge 0, drive bits of 0xA5 LSB-first on edges 1-8. Expect data_out=0xA5, valid=1 after edge 8, busy 1 from after edge 0 through edge 8.
- Same frame with enable low for 3 cycles mid-frame. Expect data_out=0xA5 after edge 11, with counter and shift register frozen while enable was low.
- Receive 0x3C with no ack, then a second frame 0xC3. Expect data_out=0xC3, valid=1, overrun=1; then ack, expect valid=0, overrun=0.
- Second frame completes on the same edge as ack of the first. Expect data_out updated, valid=1, overrun=0.
- Restart start after 4 bits, then drive 0xFF. Expect data_out=0xFF with no contamination from the partial frame; assert reset_n=0 mid-frame and expect all outputs 0 immediately.
- Parity build: 0x07 followed by parity bit 1 gives parity_err=0; with parity bit 0, expect parity_err=1 and valid after edge 9.
